// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency synchronous RAM between fetch (read) and MEM (read/write, 1 or 2 words).
// Optional macro ARB_FAIR_EN: alternate grant to IF after a MEM transaction when both are requesting.
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_double,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic              own_mem_q, we_q, dbl_q, idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt_q;
    logic              grant_mem;

    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = mem_req & ~mem_done;

`ifdef ARB_FAIR_EN
    logic last_mem_q;
    assign grant_mem = mem_req & ~(last_mem_q & if_req);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_mem_q <= 1'b0;
        else if (state_q == S_IDLE && (mem_req | if_req))
            last_mem_q <= grant_mem;
    end
`else
    assign grant_mem = mem_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            own_mem_q <= 1'b0;
            we_q      <= 1'b0;
            dbl_q     <= 1'b0;
            idx_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            mem_done <= 1'b0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            case (state_q)
                S_IDLE: if (mem_req | if_req) begin
                    own_mem_q <= grant_mem;
                    addr_q    <= grant_mem ? mem_addr : if_addr;
                    we_q      <= grant_mem & mem_we;
                    dbl_q     <= grant_mem & mem_double;
                    wdata_q   <= mem_wdata;
                    idx_q     <= 1'b0;
                    ram_en    <= 1'b1;
                    ram_we    <= grant_mem & mem_we;
                    ram_addr  <= grant_mem ? mem_addr : if_addr;
                    ram_wdata <= mem_wdata[15:0];
                    if (grant_mem) mem_rdata <= '0;
                    state_q   <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q   <= 3'(MEM_LAT);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (!we_q && !own_mem_q) if_rdata <= ram_rdata;
                        if (!we_q && own_mem_q && !idx_q) mem_rdata[15:0] <= ram_rdata;
                        if (!we_q && own_mem_q && idx_q) mem_rdata[31:16] <= ram_rdata;
                        if (dbl_q && !idx_q) begin
                            idx_q     <= 1'b1;
                            ram_en    <= 1'b1;
                            ram_we    <= we_q;
                            ram_addr  <= addr_q + ADDR_W'(1);
                            ram_wdata <= wdata_q[31:16];
                            state_q   <= S_ISSUE;
                        end else begin
                            if_valid <= ~own_mem_q;
                            mem_done <= own_mem_q;
                            state_q  <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level memory model.
module tb_mem_port_arbiter;
    localparam int LAT = 1;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, mem_req, mem_we, mem_double;
    logic [11:0] if_addr, mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic [31:0] mem_rdata;
    logic        mem_done, stall_fetch, stall_mem, ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    logic        b_if_req;
    logic [11:0] b_if_addr;
    logic [15:0] b_if_rdata;
    logic        b_if_valid;
    logic [31:0] b_mem_rdata;
    logic        b_mem_done, b_stall_fetch, b_stall_mem, b_ram_en, b_ram_we;
    logic [11:0] b_ram_addr;
    logic [15:0] b_ram_wdata, b_ram_rdata;
    logic [15:0] b_pipe [3];

    int vectors = 0, errors = 0;

    logic [15:0] ram_mem [4096];
    bit          wr_v    [4096];
    logic [15:0] ref_mem [4096];
    bit          last_mem_m;

    logic [11:0] ev_addr [4];
    logic        ev_we   [4];
    logic [15:0] ev_wd   [4];
    int          ev_n;

    mem_port_arbiter #(.ADDR_W(12), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_double(mem_double), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(12), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .mem_req(1'b0), .mem_we(1'b0), .mem_double(1'b0), .mem_addr(12'h000),
        .mem_wdata(32'h0), .mem_rdata(b_mem_rdata), .mem_done(b_mem_done),
        .stall_fetch(b_stall_fetch), .stall_mem(b_stall_mem),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    function automatic logic [15:0] init_val(input logic [11:0] a);
        return {a[3:0], a} ^ 16'h5A5A ^ {a[11:8], 12'h0};
    endfunction

    function automatic logic [15:0] b_val(input logic [11:0] a);
        return {4'hC, a} ^ 16'h0F0F;
    endfunction

    // Single-latency RAM: garbage on the read bus outside the valid cycle exposes mistimed captures.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            wr_v[ram_addr]    <= 1'b1;
        end
        ram_rdata <= (ram_en && !ram_we) ? (wr_v[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr)) : 16'($urandom);
    end

    always @(posedge clk) begin
        b_pipe[0] <= b_ram_en ? b_val(b_ram_addr) : 16'($urandom);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_ram_rdata = b_pipe[2];

    task automatic run_txn(input bit m, input bit we, input bit dbl, input logic [11:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output int first_en,
                           output bit stall_ok, output bit overlap);
        bit st;
        @(negedge clk);
        if (m) begin
            mem_req = 1'b1; mem_we = we; mem_double = dbl; mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        ev_n = 0; lat = -1; first_en = -1; overlap = 1'b0;
        #1 stall_ok = m ? stall_mem : stall_fetch;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            st = m ? stall_mem : stall_fetch;
            if (ram_en) begin
                if (first_en < 0) first_en = n;
                if (ev_n < 4) begin ev_addr[ev_n] = ram_addr; ev_we[ev_n] = ram_we; ev_wd[ev_n] = ram_wdata; end
                ev_n++;
            end
            if (if_valid && mem_done) overlap = 1'b1;
            if (m ? mem_done : if_valid) begin
                lat = n;
                if (st) stall_ok = 1'b0;
                break;
            end else if (!st) stall_ok = 1'b0;
        end
        rd = m ? mem_rdata : {16'h0, if_rdata};
        mem_req = 1'b0; if_req = 1'b0;
        last_mem_m = m;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        if_req = 0; mem_req = 0; mem_we = 0; mem_double = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        last_mem_m = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, if_rdata, if_valid, mem_rdata, mem_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h ird=%h iv=%b mrd=%h md=%b, want all 0",
                     ram_en, ram_we, ram_addr, ram_wdata, if_rdata, if_valid, mem_rdata, mem_done);
        end
        vectors++;
        if ({stall_fetch, stall_mem} !== 2'b00) begin
            errors++; $display("FAIL reset_stalls: got %b%b want 00", stall_fetch, stall_mem);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_fetch;
        logic [31:0] rd; int lat, fe; bit sok, ov;
        run_txn(1, 1, 0, 12'h020, 32'h0000A5A5, rd, lat, fe, sok, ov);
        ref_mem[12'h020] = 16'hA5A5;
        run_txn(0, 0, 0, 12'h020, 32'h0, rd, lat, fe, sok, ov);
        vectors++; if (fe !== 1) begin errors++; $display("FAIL fetch_ram_en_cycle: got %0d want 1", fe); end
        vectors++; if (lat !== LAT + 2) begin errors++; $display("FAIL fetch_latency: got %0d want %0d", lat, LAT + 2); end
        vectors++; if (rd[15:0] !== 16'hA5A5) begin errors++; $display("FAIL fetch_data: got %h want a5a5", rd[15:0]); end
        vectors++; if (!sok) begin errors++; $display("FAIL fetch_stall: got bad stall_fetch profile want high cycles 0..%0d", LAT + 1); end
    endtask

    task automatic test_double_write;
        logic [31:0] rd; int lat, fe; bit sok, ov;
        run_txn(1, 1, 1, 12'hFFF, 32'h12345678, rd, lat, fe, sok, ov);
        ref_mem[12'hFFF] = 16'h5678; ref_mem[12'h000] = 16'h1234;
        vectors++; if (ev_n !== 2) begin errors++; $display("FAIL dw_strobes: got %0d want 2", ev_n); end
        vectors++;
        if ({ev_addr[0], ev_we[0], ev_wd[0]} !== {12'hFFF, 1'b1, 16'h5678}) begin
            errors++; $display("FAIL dw_word0: got a=%h we=%b d=%h want a=fff we=1 d=5678", ev_addr[0], ev_we[0], ev_wd[0]);
        end
        vectors++;
        if ({ev_addr[1], ev_we[1], ev_wd[1]} !== {12'h000, 1'b1, 16'h1234}) begin
            errors++; $display("FAIL dw_word1_wrap: got a=%h we=%b d=%h want a=000 we=1 d=1234", ev_addr[1], ev_we[1], ev_wd[1]);
        end
        vectors++; if (lat - fe !== 2 * (LAT + 1)) begin errors++; $display("FAIL dw_issue_to_done: got %0d want %0d", lat - fe, 2 * (LAT + 1)); end
        vectors++; if (lat !== 2 * LAT + 3) begin errors++; $display("FAIL dw_latency: got %0d want %0d", lat, 2 * LAT + 3); end
        run_txn(1, 0, 1, 12'hFFF, 32'h0, rd, lat, fe, sok, ov);
        vectors++; if (rd !== 32'h12345678) begin errors++; $display("FAIL dw_readback: got %h want 12345678", rd); end
    endtask

    task automatic test_double_read;
        logic [31:0] rd; int lat, fe; bit sok, ov;
        run_txn(1, 1, 1, 12'h100, 32'hCAFEBEEF, rd, lat, fe, sok, ov);
        ref_mem[12'h100] = 16'hBEEF; ref_mem[12'h101] = 16'hCAFE;
        run_txn(1, 0, 1, 12'h100, 32'h0, rd, lat, fe, sok, ov);
        vectors++; if (rd !== 32'hCAFEBEEF) begin errors++; $display("FAIL dr_data: got %h want cafebeef", rd); end
        vectors++; if (lat !== 2 * LAT + 3) begin errors++; $display("FAIL dr_latency: got %0d want %0d", lat, 2 * LAT + 3); end
        @(negedge clk);
        vectors++; if (mem_done !== 1'b0) begin errors++; $display("FAIL dr_single_pulse: got mem_done=%b want 0", mem_done); end
    endtask

    task automatic test_contention;
        int order [2]; int got; bit ov, sf_ok, exp_mem; logic [31:0] mrd; logic [15:0] ird;
        logic [11:0] ca, cb;
        ca = 12'h300 + 12'($urandom_range(0, 15)); cb = 12'h400 + 12'($urandom_range(0, 15));
        exp_mem = !(FAIR && last_mem_m);
        order = '{-1, -1}; got = 0; ov = 0; mrd = 'x; ird = 'x;
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_double = 0; mem_addr = ca; if_req = 1; if_addr = cb;
        #1 sf_ok = stall_fetch;
        for (int n = 1; n <= 40 && got < 2; n++) begin
            @(negedge clk);
            if (if_valid && mem_done) ov = 1;
            if (mem_done) begin order[got] = 1; got++; mrd = mem_rdata; mem_req = 0; end
            else if (if_valid) begin order[got] = 0; got++; ird = if_rdata; if_req = 0; end
            else if (if_req && !stall_fetch) sf_ok = 0;
        end
        mem_req = 0; if_req = 0;
        vectors++; if (order[0] !== int'(exp_mem)) begin errors++; $display("FAIL cont_first: got %0d want %0d (1=MEM)", order[0], exp_mem); end
        vectors++; if (order[1] !== int'(!exp_mem)) begin errors++; $display("FAIL cont_second: got %0d want %0d (1=MEM)", order[1], !exp_mem); end
        vectors++; if (ov) begin errors++; $display("FAIL cont_overlap: got both pulses in one cycle want never"); end
        vectors++; if (!sf_ok) begin errors++; $display("FAIL cont_stall_fetch: got low while IF pending want high"); end
        vectors++; if (mrd !== {16'h0, ref_mem[ca]}) begin errors++; $display("FAIL cont_mem_data: got %h want %h", mrd, {16'h0, ref_mem[ca]}); end
        vectors++; if (ird !== ref_mem[cb]) begin errors++; $display("FAIL cont_if_data: got %h want %h", ird, ref_mem[cb]); end
        last_mem_m = !exp_mem;
    endtask

    task automatic test_hold;
        int h [3]; int e [3]; int got; bit lm, pi, late_if;
        lm = last_mem_m; pi = 1;
        for (int k = 0; k < 3; k++) begin
            e[k] = (FAIR && lm && pi) ? 0 : 1;
            if (e[k] == 0) pi = 0;
            lm = e[k][0];
        end
        h = '{-1, -1, -1}; got = 0; late_if = 0;
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_double = 0; mem_addr = 12'h050; if_req = 1; if_addr = 12'h060;
        for (int n = 1; n <= 60 && got < 3; n++) begin
            @(negedge clk);
            if (mem_done) begin h[got] = 1; got++; end
            else if (if_valid) begin h[got] = 0; got++; if_req = 0; end
        end
        mem_req = 0;
        if (if_req) begin
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (if_valid) begin late_if = 1; break; end
            end
            if_req = 0;
        end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (h[k] !== e[k]) begin errors++; $display("FAIL hold_grant%0d: got %0d want %0d (1=MEM)", k, h[k], e[k]); end
        end
        vectors++; if (late_if !== pi) begin errors++; $display("FAIL hold_if_after_release: got %b want %b", late_if, pi); end
        last_mem_m = pi ? 1'b0 : lm;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat, fe; bit sok, ov, quiet;
        for (int ph = 1; ph <= 2; ph++) begin
            @(negedge clk);
            mem_req = 1; mem_we = (ph == 1); mem_double = 0; mem_addr = 12'h010; mem_wdata = 32'h0000DEAD;
            repeat (ph) @(negedge clk);
            #2 reset = 1'b0;
            #1;
            vectors++;
            if ({ram_en, ram_we, mem_done} !== 3'b000) begin
                errors++; $display("FAIL rstmid%0d_drop: got en=%b we=%b done=%b want 000", ph, ram_en, ram_we, mem_done);
            end
            mem_req = 0; mem_we = 0;
            @(negedge clk);
            reset = 1'b1;
            quiet = 1;
            repeat (4) begin
                @(negedge clk);
                if (mem_done || ram_en || if_valid) quiet = 0;
            end
            vectors++; if (!quiet) begin errors++; $display("FAIL rstmid%0d_idle: got activity after reset want none", ph); end
            last_mem_m = 1'b0;
        end
        run_txn(1, 0, 0, 12'h010, 32'h0, rd, lat, fe, sok, ov);
        vectors++; if (rd !== {16'h0, ref_mem[12'h010]}) begin errors++; $display("FAIL rstmid_nowrite: got %h want %h", rd, {16'h0, ref_mem[12'h010]}); end
        vectors++; if (lat !== LAT + 2) begin errors++; $display("FAIL rstmid_fresh_latency: got %0d want %0d", lat, LAT + 2); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wd, exp; int lat, fe; bit sok, ov, m, we, dbl; logic [11:0] a, a1;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom); we = m & 1'($urandom); dbl = m & 1'($urandom);
            a = ($urandom_range(0, 4) == 0) ? 12'hFFF : 12'h200 + 12'($urandom_range(0, 7));
            a1 = a + 12'd1;
            wd = $urandom;
            exp = dbl ? {ref_mem[a1], ref_mem[a]} : {16'h0, ref_mem[a]};
            run_txn(m, we, dbl, a, wd, rd, lat, fe, sok, ov);
            if (we) begin
                ref_mem[a] = wd[15:0];
                if (dbl) ref_mem[a1] = wd[31:16];
            end else begin
                vectors++; if (rd !== exp) begin errors++; $display("FAIL rnd%0d_data: got %h want %h (m=%b d=%b a=%h)", i, rd, exp, m, dbl, a); end
            end
            vectors++;
            if (lat !== (dbl ? 2 * LAT + 3 : LAT + 2)) begin
                errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, dbl ? 2 * LAT + 3 : LAT + 2);
            end
            vectors++; if (!sok || ov) begin errors++; $display("FAIL rnd%0d_stall: got stall_ok=%b overlap=%b want 1/0", i, sok, ov); end
        end
    endtask

    task automatic test_lat3;
        int fe, vl; logic [15:0] dat; logic [11:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 12'($urandom);
            fe = -1; vl = -1; dat = 'x;
            @(negedge clk);
            b_if_req = 1; b_if_addr = a;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (b_ram_en && fe < 0) fe = n;
                if (b_if_valid) begin vl = n; dat = b_if_rdata; break; end
            end
            b_if_req = 0;
            vectors++; if (vl - fe !== 4) begin errors++; $display("FAIL lat3_%0d_en_to_valid: got %0d want 4", k, vl - fe); end
            vectors++; if (vl !== 5) begin errors++; $display("FAIL lat3_%0d_req_to_valid: got %0d want 5", k, vl); end
            vectors++; if (dat !== b_val(a)) begin errors++; $display("FAIL lat3_%0d_data: got %h want %h", k, dat, b_val(a)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        test_reset;
        test_single_fetch;
        test_double_write;
        test_double_read;
        test_contention;
        test_hold;
        test_reset_mid;
        test_random;
        test_lat3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the five-stage pipeline processor between two requesters: the Fetch stage (read-only) and the Memory stage (read/write, 1- or 2-word).
- Sequences each access against a fixed-latency synchronous RAM and produces the stall signals that freeze the pipeline while an access is pending.
- Sits between the IF/MEM stages and the memory, inside Processor.

Parameters:
- ADDR_W, 12, word-address width; 16-bit words.
- MEM_LAT, 1, RAM read latency in cycles, range 1..7; writes use the same slot length.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; level, held until if_valid.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  16  fetched instruction word.
- if_valid  out  1  one-cycle pulse: if_rdata is valid.
- mem_req  in  1  MEM-stage request; level, held until mem_done.
- mem_we  in  1  1 = write, 0 = read.
- mem_double  in  1  1 = two words: addr, then addr+1.
- mem_addr  in  ADDR_W  MEM-stage word address.
- mem_wdata  in  32  [15:0] goes to addr, [31:16] goes to addr+1.
- mem_rdata  out  32  read data, same word packing as mem_wdata; upper half is 0 for single-word accesses.
- mem_done  out  1  one-cycle pulse: access complete.
- stall_fetch  out  1  combinational: if_req & ~if_valid.
- stall_mem  out  1  combinational: mem_req & ~mem_done.
- ram_en  out  1  RAM access strobe, one cycle per word.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data, valid MEM_LAT cycles after the ram_en cycle.

Behaviour:
- Reset:
  - State goes to IDLE; all registered outputs go to 0: if_rdata, if_valid, mem_rdata, mem_done, ram_en, ram_we, ram_addr, ram_wdata; word index and latency counter go to 0.
  - Reset is asynchronous, so ram_en/ram_we drop immediately, even mid-access.
  - An in-flight transaction is abandoned; no done/valid pulse is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample the requests each edge. mem_req wins over if_req (the older instruction has priority).
  - On a grant, latch owner, addr, we, double and wdata, then go to ISSUE. Later changes on requester inputs are ignored.
- ISSUE (1 cycle):
  - ram_en=1; ram_addr = latched addr + word index, modulo 2^ADDR_W, so addr 0xFFF + 1 wraps to 0x000.
  - ram_we = latched we; ram_wdata = selected half of the latched write data.
  - Go to WAIT; counter loaded with MEM_LAT.
- WAIT:
  - ram_en=0; counter decrements each cycle.
  - In the cycle the counter reaches 1, capture ram_rdata into the selected half (reads only).
  - If double and word index = 0: set index to 1 and go to ISSUE. Otherwise go to DONE.
- DONE (1 cycle):
  - Pulse if_valid or mem_done for the owner, with data stable. No arbitration in this cycle.
  - Next state is IDLE; the requester lowers or renews its request at this edge.
- Latency, from the ISSUE cycle to the DONE cycle:
  - Single word: DONE is MEM_LAT+1 cycles after ISSUE.
  - Double word: DONE is 2·(MEM_LAT+1) cycles after the first ISSUE.
  - Request-to-done is therefore MEM_LAT+2 cycles (single) or 2·MEM_LAT+3 cycles (double).
- Simultaneous if_req and mem_req in IDLE: MEM is granted and IF stalls. stall_fetch remains high through the whole MEM transaction plus the following IF transaction.
- Dropping a request mid-transaction is illegal. The arbiter still completes the transaction and pulses done.
- if_valid and mem_done are never high in the same cycle.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined: a one-bit last_owner register (reset value 0 = IF). In IDLE, if last_owner = MEM and if_req=1, IF wins even when mem_req=1. This bounds fetch starvation to one MEM transaction.
- Undefined: strict MEM priority; the register is not built.

Test Plan:
- Reset mid-WAIT: assert reset low during a MEM read at addr 0x010 -> ram_en/ram_we drop to 0 at once, no mem_done, state is IDLE after reset is released.
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x020, RAM returns 0xA5A5 -> ram_en in cycle 1, if_valid with if_rdata=0xA5A5 in cycle 3, stall_fetch=1 for cycles 0..2.
- Double write: mem_we=1, mem_double=1, mem_addr=0xFFF, mem_wdata=0x1234_5678 -> RAM writes 0x5678 at 0xFFF, then 0x1234 at 0x000; mem_done 4 cycles after the first ISSUE.
- Double read: RAM holds 0xBEEF at 0x100 and 0xCAFE at 0x101 -> mem_rdata=0xCAFE_BEEF, one mem_done pulse.
- Contention: if_req and mem_req rise together (MEM single read) -> MEM served first, IF served next, never both pulses in one cycle. With ARB_FAIR_EN and mem_req held continuously, the grant order alternates MEM, IF, MEM.
- MEM_LAT=3 sweep of single read -> if_valid exactly 4 cycles after ram_en.
